// File: rtl/vga_sync_pkg.sv
// Shared 640x480@60 timing constants, the 3-bit RGB palette used by the
// pixel/colour stages, and a small range helper for the sync windows.
package vga_sync_pkg;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [2:0] NEGRO    = 3'b000;
    localparam logic [2:0] AZUL     = 3'b001;
    localparam logic [2:0] VERDE    = 3'b010;
    localparam logic [2:0] CIAN     = 3'b011;
    localparam logic [2:0] ROJO     = 3'b100;
    localparam logic [2:0] MAGENTA  = 3'b101;
    localparam logic [2:0] AMARILLO = 3'b110;
    localparam logic [2:0] BLANCO   = 3'b111;

    function automatic logic in_window(input logic [9:0] v,
                                       input logic [9:0] lo,
                                       input logic [9:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_counter.sv
// Mod-N counter with enable and synchronous reset; exposes the next-count
// value so callers can register decodes in step with the count itself.
module vga_counter #(
    parameter int N = 800
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic [9:0] count,
    output logic [9:0] count_next,
    output logic       wrap
);

    localparam logic [9:0] LAST = 10'(N - 1);

    assign wrap = en && (count == LAST);

    always_comb begin
        count_next = count;
        if (wrap)
            count_next = '0;
        else if (en)
            count_next = count + 10'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else
            count <= count_next;
    end

endmodule

// File: rtl/vga_sync.sv
// VGA timing generator: a 2:1 pixel-enable toggle drives horizontal and
// vertical mod-N counters; sync outputs are registered from next-count values.
module vga_sync
    import vga_sync_pkg::*;
#(
    parameter int H_DISP = H_DISPLAY,
    parameter int H_FP   = H_FRONT,
    parameter int H_SW   = H_SYNC,
    parameter int H_BP   = H_BACK,
    parameter int V_DISP = V_DISPLAY,
    parameter int V_FP   = V_FRONT,
    parameter int V_SW   = V_SYNC,
    parameter int V_BP   = V_BACK
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y
);

    localparam int HT = H_DISP + H_FP + H_SW + H_BP;
    localparam int VT = V_DISP + V_FP + V_SW + V_BP;

    localparam logic [9:0] HD    = 10'(H_DISP);
    localparam logic [9:0] VD    = 10'(V_DISP);
    localparam logic [9:0] HS_LO = 10'(H_DISP + H_FP);
    localparam logic [9:0] HS_HI = 10'(H_DISP + H_FP + H_SW - 1);
    localparam logic [9:0] VS_LO = 10'(V_DISP + V_FP);
    localparam logic [9:0] VS_HI = 10'(V_DISP + V_FP + V_SW - 1);

    logic       tick;
    logic       h_wrap;
    logic       v_wrap_unused;
    logic [9:0] h_next;
    logic [9:0] v_next;

    // Toggle rather than a divided clock: p_tick is only ever an enable.
    always_ff @(posedge clk) begin
        if (reset)
            tick <= 1'b0;
        else
            tick <= ~tick;
    end

    assign p_tick = tick;

    vga_counter #(.N(HT)) u_hcnt (
        .clk        (clk),
        .reset      (reset),
        .en         (tick),
        .count      (pixel_x),
        .count_next (h_next),
        .wrap       (h_wrap)
    );

    vga_counter #(.N(VT)) u_vcnt (
        .clk        (clk),
        .reset      (reset),
        .en         (h_wrap),
        .count      (pixel_y),
        .count_next (v_next),
        .wrap       (v_wrap_unused)
    );

    // Decoding next-count keeps the syncs aligned with the counters they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            hsync <= !in_window(h_next, HS_LO, HS_HI);
            vsync <= !in_window(v_next, VS_LO, VS_HI);
        end
    end

    assign video_on = (pixel_x < HD) && (pixel_y < VD);

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync: full-size timing over the first lines, plus a
// shrunken-timing instance so whole frames and the double wrap fit in a short run.
module tb_vga_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_d, rst_s;
    logic       d_hs, d_vs, d_vo, d_pt;
    logic [9:0] d_x, d_y;
    logic       s_hs, s_vs, s_vo, s_pt;
    logic [9:0] s_x, s_y;

    vga_sync u_dut (
        .clk(clk), .reset(rst_d), .hsync(d_hs), .vsync(d_vs),
        .video_on(d_vo), .p_tick(d_pt), .pixel_x(d_x), .pixel_y(d_y)
    );

    // 24 x 15 total: hsync low x=18..21, vsync low y=10..11, visible 16 x 8
    vga_sync #(
        .H_DISP(16), .H_FP(2), .H_SW(4), .H_BP(2),
        .V_DISP(8),  .V_FP(2), .V_SW(2), .V_BP(3)
    ) u_small (
        .clk(clk), .reset(rst_s), .hsync(s_hs), .vsync(s_vs),
        .video_on(s_vo), .p_tick(s_pt), .pixel_x(s_x), .pixel_y(s_y)
    );

    typedef struct {
        int         n;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       vo;
        logic       pt;
    } vec_t;

    vec_t        tbl[12];
    logic [19:0] exp_q[$];
    int          passed = 0;
    int          total  = 0;
    int          ed     = 0;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        ed++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, ed);
    endtask

    initial begin
        int lo_cnt, vo_cnt, pt_cnt, first_lo, fall_ed, my;
        logic prev_hs;

        // n = clk edges since reset release; x = n/2, p_tick = n odd
        tbl[0]  = '{1,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[1]  = '{2,    10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{3,    10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[3]  = '{1279, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[4]  = '{1280, 10'd640, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1311, 10'd655, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1312, 10'd656, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1503, 10'd751, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1504, 10'd752, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1599, 10'd799, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1600, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{3200, 10'd0,   10'd2, 1'b1, 1'b1, 1'b1, 1'b0};

        rst_d = 1'b1;
        rst_s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_hsync_held", int'(d_hs), 1);
            chk("reset_vsync_held", int'(d_vs), 1);
        end
        chk("reset_x",  int'(d_x), 0);
        chk("reset_y",  int'(d_y), 0);
        chk("reset_pt", int'(d_pt), 0);
        chk("reset_vo", int'(d_vo), 1);

        rst_d = 1'b0;
        ed = 0;
        for (int i = 0; i < 12; i++) begin
            while (ed < tbl[i].n) step();
            chk($sformatf("tbl%0d_x", i),  int'(d_x),  int'(tbl[i].x));
            chk($sformatf("tbl%0d_y", i),  int'(d_y),  int'(tbl[i].y));
            chk($sformatf("tbl%0d_hs", i), int'(d_hs), int'(tbl[i].hs));
            chk($sformatf("tbl%0d_vs", i), int'(d_vs), int'(tbl[i].vs));
            chk($sformatf("tbl%0d_vo", i), int'(d_vo), int'(tbl[i].vo));
            chk($sformatf("tbl%0d_pt", i), int'(d_pt), int'(tbl[i].pt));
        end

        // Line 2 in full: hsync width/start, visible pixels, pixel rate
        lo_cnt = 0; vo_cnt = 0; pt_cnt = 0; first_lo = -1;
        for (int k = 0; k < 1600; k++) begin
            step();
            if (!d_hs) begin
                lo_cnt++;
                if (first_lo < 0) first_lo = ed;
            end
            if (d_vo) vo_cnt++;
            if (d_pt) pt_cnt++;
        end
        chk("line_hsync_low_clks", lo_cnt, 192);
        chk("line_hsync_start_edge", first_lo, 3200 + 1312);
        chk("line_video_on_clks", vo_cnt, 1280);
        chk("line_p_tick_count", pt_cnt, 800);

        fall_ed = -1;
        prev_hs = d_hs;
        for (int k = 0; k < 2000 && fall_ed < 0; k++) begin
            step();
            if (prev_hs && !d_hs) fall_ed = ed;
            prev_hs = d_hs;
        end
        if (fall_ed < 0) chk("line_period_timeout", 0, 1);
        else chk("line_period_clks", fall_ed - first_lo, 1600);

        // Mid-frame reset at (300,5)
        while (ed < 8600) step();
        chk("mid_pre_x", int'(d_x), 300);
        chk("mid_pre_y", int'(d_y), 5);
        rst_d = 1'b1;
        step();
        chk("mid_rst_x",  int'(d_x), 0);
        chk("mid_rst_y",  int'(d_y), 0);
        chk("mid_rst_hs", int'(d_hs), 1);
        chk("mid_rst_vs", int'(d_vs), 1);
        chk("mid_rst_pt", int'(d_pt), 0);
        rst_d = 1'b0;
        ed = 0;
        step();
        chk("resume_pt1", int'(d_pt), 1);
        chk("resume_x1",  int'(d_x), 0);
        step();
        chk("resume_x2",  int'(d_x), 1);
        while (ed < 1312) step();
        chk("resume_hs_x",  int'(d_x), 656);
        chk("resume_hs_lo", int'(d_hs), 0);

        // Shrunken instance: one whole frame of 24*15*2 = 720 clk
        rst_s = 1'b0;
        ed = 0;
        lo_cnt = 0; vo_cnt = 0; pt_cnt = 0; first_lo = -1;
        for (int k = 0; k < 720; k++) begin
            step();
            my = (ed / 48) % 15;
            if (!s_vs) begin
                lo_cnt++;
                if (first_lo < 0) first_lo = ed;
            end
            if (s_vo && my < 8) vo_cnt++;
            if (s_vo && my >= 8) pt_cnt++;
        end
        chk("frame_vsync_low_clks", lo_cnt, 96);
        chk("frame_vsync_start_edge", first_lo, 480);
        chk("frame_video_on_clks", vo_cnt, 256);
        chk("frame_video_on_blank_rows", pt_cnt, 0);
        chk("frame_period_x", int'(s_x), 0);
        chk("frame_period_y", int'(s_y), 0);

        // Double wrap (23,14) -> (0,0) on one edge
        while (ed < 1439) step();
        exp_q.push_back({10'd14, 10'd23});
        exp_q.push_back({10'd0, 10'd0});
        exp_q.push_back({10'd0, 10'd0});
        exp_q.push_back({10'd0, 10'd1});
        chk("wrap_pre_pt", int'(s_pt), 1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            chk($sformatf("wrap_seq%0d_xy", k), int'({s_y, s_x}), int'(exp_q.pop_front()));
        end

        // Mid-frame reset on the shrunken instance at (12,6)
        while (ed < 1440 + 6 * 48 + 24) step();
        chk("s_mid_pre_x", int'(s_x), 12);
        chk("s_mid_pre_y", int'(s_y), 6);
        rst_s = 1'b1;
        step();
        chk("s_mid_rst_xy", int'({s_y, s_x}), 0);
        chk("s_mid_rst_vo", int'(s_vo), 1);
        rst_s = 1'b0;
        step();
        step();
        chk("s_resume_x", int'(s_x), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
